// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the I2S / left-justified stream transmitter.
package i2s_pkg;

    localparam logic I2S_FMT_I2S = 1'b0;
    localparam logic I2S_FMT_LJ  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/i2s_sample_fifo.sv
// First-word-fall-through sample FIFO with level output; the head word is visible on rd_data whenever not empty.
module i2s_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_tx_stream.sv
// Parametrised I2S / left-justified stereo transmitter fed from a sample-pair FIFO.
// Optional underrun counter (cnt_clr_i, underrun_cnt_o) is built when I2S_TX_UNDERRUN_CNT_EN is defined.
//
// state   | meaning
// ST_IDLE | serialiser stopped, outputs 0, fmt_i tracked every cycle
// ST_RUN  | BCLK running, frames loaded from the FIFO at each b=0
module i2s_tx_stream
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int BCLK_HALF  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable_i,
    input  logic                               fmt_i,
    input  logic                               s_valid_i,
    output logic                               s_ready_o,
    input  logic [SAMPLE_W-1:0]                l_sample_i,
    input  logic [SAMPLE_W-1:0]                r_sample_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o,
    output logic                               underrun_o,
`ifdef I2S_TX_UNDERRUN_CNT_EN
    input  logic                               cnt_clr_i,
    output logic [15:0]                        underrun_cnt_o,
`endif
    output logic                               lrclk_o,
    output logic                               bclk_o,
    output logic                               dacdat_o
);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int DIV_W   = $clog2(BCLK_HALF);
    localparam int B_W     = $clog2(FRAME_W);

    i2s_state_e              state_q, state_d;
    logic [DIV_W-1:0]        div_q;
    logic [B_W-1:0]          b_q, b_next;
    logic [FRAME_W-1:0]      sreg_q, sreg_next, frame_word;
    logic                    bclk_q, lrclk_q, dacdat_q, lj_q, underrun_q, fmt_q;
    logic                    div_tc, frame_start, pop, underrun_evt;
    logic                    fifo_full, fifo_empty;
    logic [2*SAMPLE_W-1:0]   fifo_head;
    logic [SLOT_W-1:0]       l_slot, r_slot;

    i2s_sample_fifo #(
        .WIDTH (2 * SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (s_valid_i),
        .wr_data ({l_sample_i, r_sample_i}),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_o)
    );

    assign s_ready_o = !fifo_full;

    // Samples sit MSB-aligned in their slot, zero-padded below.
    assign l_slot     = SLOT_W'(fifo_head[2*SAMPLE_W-1:SAMPLE_W]) << (SLOT_W - SAMPLE_W);
    assign r_slot     = SLOT_W'(fifo_head[SAMPLE_W-1:0]) << (SLOT_W - SAMPLE_W);
    assign frame_word = fifo_empty ? '0 : {l_slot, r_slot};
    assign div_tc     = (div_q == DIV_W'(BCLK_HALF - 1));
    assign b_next     = (b_q == B_W'(FRAME_W - 1)) ? '0 : b_q + B_W'(1);
    assign sreg_next  = frame_start ? frame_word : (sreg_q << 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_i)  state_d = ST_RUN;
            ST_RUN:  if (!enable_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        if (enable_i) begin
            if (state_q == ST_IDLE) begin
                frame_start = 1'b1;
            end else if (div_tc && bclk_q && (b_next == '0)) begin
                frame_start = 1'b1;
            end
        end
        pop          = frame_start && !fifo_empty;
        underrun_evt = frame_start && fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            b_q        <= '0;
            sreg_q     <= '0;
            lj_q       <= 1'b0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            dacdat_q   <= 1'b0;
            underrun_q <= 1'b0;
            fmt_q      <= I2S_FMT_I2S;
        end else if (!enable_i) begin
            div_q      <= '0;
            b_q        <= '0;
            sreg_q     <= '0;
            lj_q       <= 1'b0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            dacdat_q   <= 1'b0;
            underrun_q <= 1'b0;
            fmt_q      <= fmt_i;
        end else begin
            underrun_q <= underrun_evt;
            if (state_q == ST_IDLE) begin
                div_q    <= '0;
                b_q      <= '0;
                bclk_q   <= 1'b0;
                lrclk_q  <= 1'b0;
                sreg_q   <= sreg_next;
                lj_q     <= sreg_next[FRAME_W-1];
                // lj_q is still 0 here, so I2S period 0 of the first frame is 0.
                dacdat_q <= (fmt_i == I2S_FMT_LJ) ? sreg_next[FRAME_W-1] : lj_q;
                fmt_q    <= fmt_i;
            end else if (div_tc) begin
                div_q  <= '0;
                bclk_q <= !bclk_q;
                if (bclk_q) begin
                    b_q      <= b_next;
                    sreg_q   <= sreg_next;
                    lj_q     <= sreg_next[FRAME_W-1];
                    lrclk_q  <= (b_next >= B_W'(SLOT_W));
                    dacdat_q <= (fmt_q == I2S_FMT_LJ) ? sreg_next[FRAME_W-1] : lj_q;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign bclk_o     = bclk_q;
    assign lrclk_o    = lrclk_q;
    assign dacdat_o   = dacdat_q;
    assign underrun_o = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || cnt_clr_i) begin
            underrun_cnt_o <= '0;
        end else if (underrun_evt && (underrun_cnt_o != 16'hFFFF)) begin
            underrun_cnt_o <= underrun_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: doc/i2s_tx_stream.md
# i2s_tx_stream

Parametrised I2S/left-justified transmitter, successor to the fixed 16-bit stereo encoder. Accepts stereo sample pairs over a valid/ready stream into an internal FIFO, then serialises them MSB-first with configurable sample width, slot width, BCLK divider and frame format. It sits between the audio mixer/DMA path and the external DAC pins, and reports FIFO level and underruns.

## Interface
- `SAMPLE_W`, 16: bits per sample. Range 8..SLOT_W.
- `SLOT_W`, 32: BCLK periods per channel slot. Frame length is 2*SLOT_W.
- `BCLK_HALF`, 8: clk cycles per BCLK half-period, at least 2. At 48 MHz with the defaults: BCLK 3 MHz, fs 46.875 kHz.
- `FIFO_DEPTH`, 8: stereo pairs buffered. Power of two, at least 2.
- `clk` in 1: system clock, 48 MHz.
- `reset` in 1: synchronous reset, active-high.
- `enable_i` in 1: run the serialiser.
- `fmt_i` in 1: 0 = I2S (one-BCLK data delay), 1 = left-justified. Sampled only while idle.
- `s_valid_i` in 1: sample pair valid.
- `s_ready_o` out 1: FIFO not full.
- `l_sample_i` in SAMPLE_W: left sample, two's complement.
- `r_sample_i` in SAMPLE_W: right sample, two's complement.
- `fifo_level_o` out $clog2(FIFO_DEPTH+1): number of stored pairs.
- `underrun_o` out 1: one-clk pulse when a frame starts with the FIFO empty.
- `lrclk_o`, `bclk_o`, `dacdat_o` out 1 each: serial outputs.

## Operation
- Push: the FIFO stores {l,r} when `s_valid_i && s_ready_o`, and `s_ready_o = !full`. There is no bypass, so a pair pushed in the same cycle as a frame start is not used by that frame.
- Idle state (reset, or `enable_i` low):
  - The divider, bit index b and shift registers are held at 0.
  - All serial outputs are 0.
  - `fmt_i` is latched each cycle.
  - The FIFO still accepts pushes.
- Start: the first cycle `enable_i` is high while idle is a frame start at b=0.
- Running: the divider counts 0..BCLK_HALF-1. At the terminal count `bclk_o` toggles.
  - 0→1: rising edge, no data change.
  - 1→0: falling edge, b ← (b+1) mod 2*SLOT_W.
  - Falling edge into b=0: frame start.
- Frame start:
  - If the FIFO is non-empty: pop the head, and load the frame register with L and R, each MSB-aligned in its SLOT_W slot and zero-padded below.
  - If the FIFO is empty: load zeros and pulse `underrun_o`.
- LRCLK: `lrclk_o` is 0 for b < SLOT_W (left slot) and 1 otherwise, in both formats.
- Data:
  - Left-justified: `dacdat_o` in period b is bit (SLOT_W-1 - b mod SLOT_W) of the current channel's slot word.
  - I2S: the left-justified stream delayed by one BCLK period through a 1-bit register. The right-channel LSB of frame N appears in period 0 of frame N+1, and the MSB of left lands in period 1.
- `enable_i` falling: the block returns to idle immediately, all outputs go to 0, and the in-flight frame is dropped without a pop.
- `reset` mid-operation: next edge gives outputs 0, FIFO flushed (level 0), counters cleared, and `fmt_i` latch = 0.

## Timing
- Reset values: `lrclk_o`, `bclk_o`, `dacdat_o`, `underrun_o` = 0. `fifo_level_o` = 0. `s_ready_o` = 1 in the cycle after reset deasserts.
- All outputs are registered. `lrclk_o` and `dacdat_o` change only on the same clk edge where `bclk_o` goes 1→0.
- Frame start at the enable cycle: `bclk_o` rises BCLK_HALF cycles later and falls 2*BCLK_HALF cycles later (b=1).
- Pop/push latency: `fifo_level_o` updates one cycle after a push or pop. A simultaneous push and pop leaves the level unchanged.
- `underrun_o` is asserted in the cycle after the frame-start edge, for exactly one clk.

## Configuration
- `I2S_TX_UNDERRUN_CNT_EN` defined:
  - Adds input `cnt_clr_i` and output `underrun_cnt_o` [15:0].
  - The counter increments on each underrun and saturates at 0xFFFF.
  - `cnt_clr_i` zeroes it, and clear wins over a simultaneous increment.
  - Reset value is 0.
- Without the macro: these ports and the counter do not exist. `underrun_o` is unaffected.

## Structure
- Package `i2s_pkg`: constants `I2S_FMT_I2S = 1'b0` and `I2S_FMT_LJ = 1'b1`.
- Sub-module `i2s_sample_fifo`: synchronous first-word-fall-through FIFO, width 2*SAMPLE_W, depth FIFO_DEPTH, with level output.
- The divider, bit index, shifter and delay register live in the top module.

## Test plan
- Defaults, LJ, push L=0x8001, R=0x7FFE, enable: frame 1 carries L bits MSB-first in b=0..15 and zeros in b=16..31 with LRCLK=0, then R in b=32..47 with LRCLK=1. BCLK period is 16 clk.
- Same pair in I2S mode: `dacdat_o` equals the LJ sequence delayed by exactly one BCLK period, and the left MSB is in b=1.
- Enable with an empty FIFO: `underrun_o` pulses once per frame, `dacdat_o` stays 0 and LRCLK still toggles. With the macro defined, `underrun_cnt_o` reaches 3 after 3 frames; `cnt_clr_i` then gives 0.
- Push 9 pairs back-to-back while disabled (FIFO_DEPTH=8): `s_ready_o` drops after the 8th, `fifo_level_o` = 8, and the 9th pair is not accepted. Enable: the pairs are popped one per frame in order.
- SAMPLE_W=24, SLOT_W=24, BCLK_HALF=2: L=0xABCDEF serialises as 24 bits with no padding, and the frame is 48 BCLKs of 4 clk each.
- `reset` asserted mid-frame with 3 pairs queued: next cycle all outputs are 0 and level is 0. After re-enable, the first frame underruns.
